// File: rtl/matrix_pkg.sv
// Shared matrix types: element geometry, row-major element index and the reader state encoding.
// READER_OVF_TAG_EN adds the TAG state used to append the overflow beat.
package matrix_pkg;

    localparam int EW    = 8;
    localparam int N_MAX = 5;
    localparam int MAT_W = N_MAX * N_MAX * EW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
`ifdef READER_OVF_TAG_EN
        ,
        ST_TAG    = 2'd3
`endif
    } reader_state_e;

    function automatic logic [4:0] elem_idx(input logic [2:0] r, input logic [2:0] c);
        return 5'(r) * 5'(N_MAX) + 5'(c);
    endfunction

endpackage

// File: rtl/matrix_elem_sel.sv
// Purpose: 25:1 element mux selecting (row,col) from the packed row-major matrix.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller holds row/col steady while stalled.
module matrix_elem_sel #(
    parameter int EW    = matrix_pkg::EW,
    parameter int N_MAX = matrix_pkg::N_MAX
) (
    input  logic [N_MAX*N_MAX*EW-1:0] mat,
    input  logic [2:0]                row,
    input  logic [2:0]                col,
    output logic [EW-1:0]             elem
);
    import matrix_pkg::elem_idx;

    localparam int NE  = N_MAX * N_MAX;
    localparam int TOP = NE * EW - 1;

    logic [4:0] idx;
    assign idx = elem_idx(row, col);

    always_comb begin
        elem = '0;
        for (int k = 0; k < NE; k++) begin
            if (idx == 5'(k)) elem = mat[TOP - EW*k -: EW];
        end
    end

endmodule

// File: rtl/matrix_result_reader.sv
// Purpose: captures a result matrix on start and streams its size*size elements row-major (optional ovf tag beat: READER_OVF_TAG_EN).
// Latency: first beat valid one cycle after capture; done pulses one cycle after the final beat.
// Backpressure: valid/ready; data, row and column hold while out_ready is low.
module matrix_result_reader #(
    parameter int EW    = matrix_pkg::EW,
    parameter int N_MAX = matrix_pkg::N_MAX
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MAX*N_MAX*EW-1:0] res_in,
    input  logic                      ovf_in,
    input  logic [2:0]                size,
    input  logic                      start,
    output logic                      busy,
    output logic [EW-1:0]             out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      done,
    output logic                      err
);
    import matrix_pkg::*;

    reader_state_e             state_q;
    logic [N_MAX*N_MAX*EW-1:0] data_q;
    logic [2:0]                size_q;
    logic [2:0]                row_q;
    logic [2:0]                col_q;
    logic                      busy_q;
    logic                      valid_q;
    logic                      last_q;
    logic                      done_q;
    logic                      err_q;
    logic [EW-1:0]             elem;
    logic [2:0]                last_idx;
    logic                      size_ok;

    assign last_idx = size_q - 3'd1;
    assign size_ok  = (size >= 3'd2) && (32'(size) <= N_MAX);

    matrix_elem_sel #(.EW(EW), .N_MAX(N_MAX)) u_sel (
        .mat  (data_q),
        .row  (row_q),
        .col  (col_q),
        .elem (elem)
    );

`ifdef READER_OVF_TAG_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        ovf_q <= 1'b0;
        else if (state_q == ST_IDLE && start && size_ok)   ovf_q <= ovf_in;
    end

    assign out_data = (state_q == ST_TAG) ? {{(EW-1){1'b0}}, ovf_q} : elem;
`else
    assign out_data = elem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            size_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && size_ok) begin
                        data_q  <= res_in;
                        size_q  <= size;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= ST_STREAM;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (col_q == last_idx) begin
                            col_q <= '0;
                            if (row_q == last_idx) begin
                                row_q <= '0;
`ifdef READER_OVF_TAG_EN
                                last_q  <= 1'b1;
                                state_q <= ST_TAG;
`else
                                busy_q  <= 1'b0;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
`endif
                            end else begin
                                row_q <= row_q + 3'd1;
                            end
                        end else begin
                            col_q <= col_q + 3'd1;
`ifndef READER_OVF_TAG_EN
                            // Flag the beat about to be presented if it is the last element.
                            last_q <= (row_q == last_idx) && (col_q + 3'd1 == last_idx);
`endif
                        end
                    end
                end
`ifdef READER_OVF_TAG_EN
                ST_TAG: begin
                    if (out_ready) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Directed bench for matrix_result_reader: ramp matrix frames of several sizes, stalls, illegal size and mid-frame reset.
module tb_matrix_result_reader;

`ifdef READER_OVF_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [199:0] res_in = '0;
    logic         ovf_in = 1'b0;
    logic [2:0]   size = 3'd0;
    logic         start = 1'b0;
    logic         busy;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         done;
    logic         err;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] beats[$];
    bit         lasts[$];
    logic [199:0] ramp;

    matrix_result_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_in    (res_in),
        .ovf_in    (ovf_in),
        .size      (size),
        .start     (start),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the frame already captured; collects accepted beats until done.
    task automatic stream(input bit toggle);
        int   cyc = 0;
        int   last_cyc = -1;
        int   gap = -1;
        bit   hold_chk = 0;
        logic [7:0] held = '0;
        beats.delete();
        lasts.delete();
        while (cyc < 300) begin
            out_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
            if (hold_chk && out_valid) chk("stall_hold", 32'(out_data), 32'(held));
            hold_chk = 0;
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
                last_cyc = cyc;
            end else if (out_valid) begin
                held = out_data;
                hold_chk = 1;
            end
            if (done) begin
                gap = cyc - last_cyc;
                chk("done_valid", 32'(out_valid), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
                break;
            end
            cyc++;
            @(negedge clk);
        end
        chk("done_gap", 32'(gap), 32'd1);
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int s, input bit ovf);
        int n_exp = s*s + TAG_EN;
        int n = beats.size();
        logic [7:0] exp;
        chk({tag, "_nbeats"}, 32'(n), 32'(n_exp));
        for (int i = 0; i < n && i < n_exp; i++) begin
            exp = (i < s*s) ? 8'(5*(i/s) + (i%s) + 1) : {7'b0, ovf};
            chk({tag, "_data"}, 32'(beats[i]), 32'(exp));
            chk({tag, "_last"}, 32'(lasts[i]), 32'(i == n_exp-1));
        end
    endtask

    task automatic launch(input int s, input bit ovf);
        res_in = ramp;
        ovf_in = ovf;
        size = 3'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cap_busy", 32'(busy), 32'd1);
        chk("cap_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 25; k++) ramp[199 - 8*k -: 8] = 8'(k + 1);

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // Full 5x5 frame, sink always ready.
        launch(5, 1'b0);
        stream(1'b0);
        check_frame("s5", 5, 1'b0);

        // 3x3 sub-matrix.
        launch(3, 1'b0);
        stream(1'b0);
        check_frame("s3", 3, 1'b0);

        // 2x2 with stalls; a start mid-frame carrying different data must be ignored.
        launch(2, 1'b0);
        res_in = '1;
        size = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stream(1'b1);
        check_frame("s2", 2, 1'b0);

        // Illegal size.
        size = 3'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("err_clear", 32'(err), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);
        chk("err_valid2", 32'(out_valid), 32'd0);

        // Reset after the 7th beat of a 5x5 frame.
        launch(5, 1'b0);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 7; c++) begin
            if (out_valid && out_ready) n++;
            if (n < 7) @(negedge clk);
        end
        chk("rst7_seen", 32'(n), 32'd7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        launch(5, 1'b0);
        stream(1'b0);
        check_frame("post_rst", 5, 1'b0);

        // Overflow tag (a plain 16-beat frame when the tag is disabled).
        launch(4, 1'b1);
        stream(1'b0);
        check_frame("ovf1", 4, 1'b1);
        launch(4, 1'b0);
        stream(1'b0);
        check_frame("ovf0", 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
